// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative radix-2 shift-add multiplier with ripple-adder datapath
//
// Purpose:
//   Produces the full 2*DATA_WIDTH product of two DATA_WIDTH operands, one
//   partial-product step per clock, DATA_WIDTH steps per operation. Signed
//   operands are handled by subtracting (rather than adding) the final partial
//   product, because the MSB of a two's-complement multiplier has negative weight.
//
// Ports (seq_multiplier):
//   clk_i           system clock, all state updates on the rising edge
//   reset_i         synchronous, active-high reset
//   start_i         request a multiply; accepted only in IDLE or DONE
//   is_signed_i     1 = two's-complement operands, 0 = unsigned
//   multiplicand_i  operand M, sampled on the accepting edge
//   multiplier_i    operand Q, sampled on the accepting edge
//   busy_o          high while iterating
//   done_o          one-cycle pulse, product valid
//   product_lo_o    low half of the product
//   product_hi_o    high half of the product
//
// Ports (ripple_adder):
//   a_i, b_i        addends
//   sub_i           1 = a_i - b_i, 0 = a_i + b_i
//   sum_o           result
//   carry_o         carry out of the MSB
//   overflow_o      signed overflow

module ripple_adder #(
  parameter int WIDTH = 65
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  // Subtraction is a + ~b + 1: invert b and inject the +1 as the carry-in.
  always_comb begin
    logic [WIDTH-1:0] b_x;
    logic             c;
    b_x   = sub_i ? ~b_i : b_i;
    c     = sub_i;
    sum_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i] = a_i[i] ^ b_x[i] ^ c;
      c        = (a_i[i] & b_x[i]) | (c & (a_i[i] ^ b_x[i]));
    end
    carry_o    = c;
    overflow_o = (a_i[WIDTH-1] == b_x[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
  end

endmodule

module seq_multiplier #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  is_signed_i,
  input  logic [DATA_WIDTH-1:0] multiplicand_i,
  input  logic [DATA_WIDTH-1:0] multiplier_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] product_lo_o,
  output logic [DATA_WIDTH-1:0] product_hi_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [W:0]      acc_q;
  logic [W-1:0]    q_q;
  logic [W-1:0]    m_q;
  logic            signed_q;
  logic [CW-1:0]   count_q;
  logic            busy_q;
  logic            done_q;
  logic [W-1:0]    prod_lo_q;
  logic [W-1:0]    prod_hi_q;

  logic [W:0]      m_ext;
  logic            last_step;
  logic            add_sub;
  logic [W:0]      add_sum;
  logic [W:0]      step_s;
  logic            fill;
  logic [W:0]      acc_d;
  logic [W-1:0]    q_d;
  logic            unused_carry;
  logic            unused_overflow;

  // One extra accumulator bit holds the sign (signed) or the carry (unsigned),
  // so acc +/- M_ext can never overflow.
  always_comb begin
    m_ext     = {signed_q & m_q[W-1], m_q};
    last_step = (count_q == CW'(W - 1));
    add_sub   = signed_q & last_step;
  end

  ripple_adder #(
    .WIDTH (W + 1)
  ) u_adder (
    .a_i        (acc_q),
    .b_i        (m_ext),
    .sub_i      (add_sub),
    .sum_o      (add_sum),
    .carry_o    (unused_carry),
    .overflow_o (unused_overflow)
  );

  // Shift the {fill, s, q} concatenation right by one: the bit leaving the
  // accumulator becomes the new MSB of q, q's LSB (already consumed) drops out.
  always_comb begin
    step_s = q_q[0] ? add_sum : acc_q;
    fill   = signed_q & step_s[W];
    acc_d  = {fill, step_s[W:1]};
    q_d    = {step_s[0], q_q[W-1:1]};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      q_q       <= '0;
      m_q       <= '0;
      signed_q  <= 1'b0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      prod_lo_q <= '0;
      prod_hi_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            m_q      <= multiplicand_i;
            signed_q <= is_signed_i;
            acc_q    <= '0;
            q_q      <= multiplier_i;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          // start_i is deliberately not looked at here: a running operation
          // cannot be restarted or re-sampled.
          acc_q   <= acc_d;
          q_q     <= q_d;
          count_q <= count_q + 1'b1;
          if (last_step) begin
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            prod_hi_q <= acc_d[W-1:0];
            prod_lo_q <= q_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign product_lo_o = prod_lo_q;
  assign product_hi_o = prod_hi_q;

endmodule
